// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline register (main + skid) with bubble-gated control,
// flush, and saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 111,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  BubbleCount
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    logic xfer_in_s;
    logic xfer_out_s;
    logic ld_main_in_s;
    logic ld_main_skid_s;
    logic ld_skid_s;
    logic clr_main_ctrl_s;
    logic stall_inc_s;
    logic bubble_inc_s;

    assign xfer_in_s  = InValid && in_ready_r;
    assign xfer_out_s = out_valid_r && OutReady;

    // Next-state and register load-enable decode for the handshake path.
    always_comb begin
        state_nxt_s     = state_r;
        ld_main_in_s    = 1'b0;
        ld_main_skid_s  = 1'b0;
        ld_skid_s       = 1'b0;
        clr_main_ctrl_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_in_s) begin
                    state_nxt_s  = ST_FULL;
                    ld_main_in_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_out_s && xfer_in_s) begin
                    state_nxt_s  = ST_FULL;
                    ld_main_in_s = 1'b1;
                end else if (xfer_out_s) begin
                    state_nxt_s     = ST_EMPTY;
                    clr_main_ctrl_s = 1'b1;
                end else if (xfer_in_s) begin
                    state_nxt_s = ST_SKID;
                    ld_skid_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_SKID: begin
                if (xfer_out_s) begin
                    state_nxt_s    = ST_FULL;
                    ld_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SKID;
                end
            end
            default: begin
                state_nxt_s     = ST_EMPTY;
                clr_main_ctrl_s = 1'b1;
            end
        endcase
    end

    // State plus registered ready/valid, so neither output is combinational from OutReady.
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_SKID);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Control fields: zeroed whenever the stage empties so a bubble has no side effects.
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            main_ctrl_r <= '0;
            skid_ctrl_r <= '0;
        end else begin
            if (ld_main_in_s) begin
                main_ctrl_r <= InCtrl;
            end else if (ld_main_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
            end else if (clr_main_ctrl_s) begin
                main_ctrl_r <= '0;
            end else begin
                main_ctrl_r <= main_ctrl_r;
            end
            if (ld_skid_s) begin
                skid_ctrl_r <= InCtrl;
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
            end
        end
    end

    // Payload registers: load only on their load events; a flush leaves them untouched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_data_r <= '0;
            skid_data_r <= '0;
        end else if (Flush) begin
            main_data_r <= main_data_r;
            skid_data_r <= skid_data_r;
        end else begin
            if (ld_main_in_s) begin
                main_data_r <= InData;
            end else if (ld_main_skid_s) begin
                main_data_r <= skid_data_r;
            end else begin
                main_data_r <= main_data_r;
            end
            if (ld_skid_s) begin
                skid_data_r <= InData;
            end else begin
                skid_data_r <= skid_data_r;
            end
        end
    end

    assign stall_inc_s  = out_valid_r && !OutReady && (stall_cnt_r != CNT_MAX);
    assign bubble_inc_s = !out_valid_r && (bubble_cnt_r != CNT_MAX);

    // Saturating performance counters; only Reset clears them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r  <= '0;
            bubble_cnt_r <= '0;
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (bubble_inc_s) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign InReady     = in_ready_r;
    assign OutValid    = out_valid_r;
    assign OutCtrl     = main_ctrl_r;
    assign OutData     = main_data_r;
    assign StallCount  = stall_cnt_r;
    assign BubbleCount = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg with an in-order scoreboard queue
// and a reference occupancy/counter model.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 10;
    localparam int DATA_W = 111;
    localparam int CNT_W  = 4;
    localparam int ENT_W  = CTRL_W + DATA_W;

    logic              Clk;
    logic              Reset;
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [CTRL_W-1:0] InCtrl;
    logic [DATA_W-1:0] InData;
    logic              OutValid;
    logic              OutReady;
    logic [CTRL_W-1:0] OutCtrl;
    logic [DATA_W-1:0] OutData;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  BubbleCount;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .InCtrl(InCtrl), .InData(InData),
        .OutValid(OutValid), .OutReady(OutReady), .OutCtrl(OutCtrl), .OutData(OutData),
        .StallCount(StallCount), .BubbleCount(BubbleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [ENT_W-1:0] sb_q[$];
    logic [CNT_W-1:0] stall_m;
    logic [CNT_W-1:0] bubble_m;
    int tests;
    int fails;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check outputs.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                         input logic ordy);
        logic exp_valid;
        logic xin;
        logic xout;
        Reset = rst; Flush = fl; InValid = iv; InCtrl = ic; InData = id; OutReady = ordy;
        exp_valid = (sb_q.size() > 0);
        xin  = iv && (sb_q.size() < 2);
        xout = exp_valid && ordy;
        @(posedge Clk);
        #1;
        if (rst) begin
            sb_q.delete();
            stall_m  = '0;
            bubble_m = '0;
        end else begin
            if (exp_valid && !ordy && stall_m != 4'hF) stall_m = stall_m + 4'd1;
            if (!exp_valid && bubble_m != 4'hF) bubble_m = bubble_m + 4'd1;
            if (fl) begin
                sb_q.delete();
            end else begin
                if (xout) void'(sb_q.pop_front());
                if (xin) sb_q.push_back({ic, id});
            end
        end
        chk("out_valid", {127'd0, OutValid}, {127'd0, (sb_q.size() > 0)});
        chk("in_ready", {127'd0, InReady}, {127'd0, (sb_q.size() < 2)});
        chk("stall_cnt", {124'd0, StallCount}, {124'd0, stall_m});
        chk("bubble_cnt", {124'd0, BubbleCount}, {124'd0, bubble_m});
        if (sb_q.size() > 0) begin
            chk("out_ctrl", {118'd0, OutCtrl}, {118'd0, sb_q[0][ENT_W-1:DATA_W]});
            chk("out_data", {17'd0, OutData}, {17'd0, sb_q[0][DATA_W-1:0]});
        end else begin
            chk("out_ctrl_bubble", {118'd0, OutCtrl}, 128'd0);
        end
        if (rst) chk("out_data_rst", {17'd0, OutData}, 128'd0);
    endtask

    localparam logic [CTRL_W-1:0] C1 = 10'h3FF;
    localparam logic [CTRL_W-1:0] C0 = 10'h000;

    initial begin
        logic [DATA_W-1:0] rd;
        tests = 0; fails = 0;
        stall_m = '0; bubble_m = '0;
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; InCtrl = '0; InData = '0; OutReady = 1'b0;

        // reset state
        cycle(1'b1, 1'b0, 1'b0, C0, 111'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, C0, 111'd0, 1'b0);

        // bubble gating: all-ones ctrl without valid never reaches the output
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, C1, 111'h55, 1'b1);

        // streaming 1..4 with no stalls
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 10'h0A5 + 10'(i), 111'(i), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);

        // backpressure into skid, hold, then drain A then B
        cycle(1'b0, 1'b0, 1'b1, 10'h011, 111'hA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10'h022, 111'hB, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10'h033, 111'hF, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);

        // flush in skid with C offered: C must never appear
        cycle(1'b0, 1'b0, 1'b1, 10'h044, 111'hD, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10'h055, 111'hE, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 10'h066, 111'hC, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);
        // flush coinciding with a transfer out
        cycle(1'b0, 1'b0, 1'b1, 10'h077, 111'h7, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 10'h088, 111'h8, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 10'h099, 111'h9, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);

        // stall counter saturation at 15
        cycle(1'b0, 1'b0, 1'b1, 10'h1AB, 111'h123, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b0);
        chk("stall_sat", {124'd0, StallCount}, 128'd15);

        // reset during FULL with StallCount=3
        cycle(1'b1, 1'b0, 1'b0, C0, 111'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10'h2CD, 111'h456, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b0);
        chk("stall_pre_rst", {124'd0, StallCount}, 128'd3);
        cycle(1'b1, 1'b0, 1'b1, 10'h3EE, 111'h789, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, C0, 111'd0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                  CTRL_W'($urandom), rd, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 10, giving the control-field width (RegWrite, MemtoReg, MemWrite, MemRead, ALUOp[1:0], RegDst, ALUSrc, spare[1:0]).
REQ-002 The block SHALL have parameter DATA_W, default 111, giving the payload width (two register operands, sign-extended immediate, rs/rt/rd).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 The port list SHALL be as follows:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- Flush  in  1  discard all held entries (bubble insert)
- InValid  in  1  upstream entry present
- InReady  out  1  stage can accept an entry this cycle
- InCtrl  in  CTRL_W  upstream control field
- InData  in  DATA_W  upstream payload
- OutValid  out  1  entry presented downstream
- OutReady  in  1  downstream accepts this cycle
- OutCtrl  out  CTRL_W  downstream control field
- OutData  out  DATA_W  downstream payload
- StallCount  out  CNT_W  saturating count of stalled cycles
- BubbleCount  out  CNT_W  saturating count of empty cycles

Function
REQ-006 The block SHALL be a two-entry elastic register (main plus skid) with states EMPTY, FULL (main held) and SKID (main and skid held).
REQ-007 A transfer in SHALL occur on a rising edge where InValid=1 and InReady=1; a transfer out SHALL occur on a rising edge where OutValid=1 and OutReady=1.
REQ-008 InReady SHALL be 1 in EMPTY and FULL and 0 in SKID; it SHALL be a registered function of state, not combinational from OutReady.
REQ-009 OutValid SHALL be 1 exactly in FULL and SKID; OutCtrl/OutData SHALL always present the main entry.
REQ-010 Transitions from EMPTY: a transfer in SHALL load main and move to FULL; otherwise the block SHALL stay in EMPTY.
REQ-011 Transitions from FULL:
- transfer out without transfer in -> EMPTY
- transfer out with transfer in -> FULL, main loaded with the new entry
- transfer in without transfer out -> SKID, skid loaded
- neither -> hold
REQ-012 Transitions from SKID: a transfer out SHALL copy skid into main and move to FULL; otherwise the block SHALL hold.
REQ-013 Latency SHALL be one cycle from transfer in to OutValid, throughput SHALL be one entry per cycle with OutReady=1, and entry order SHALL be preserved.
REQ-014 OutCtrl SHALL be all-zero whenever OutValid=0, so that an empty stage is a bubble with no side effects.
REQ-015 Flush=1 at a rising edge SHALL force EMPTY, discard main, skid and any same-cycle input, and zero the held control fields; data fields SHALL be left unchanged.
REQ-016 Priority SHALL be Reset, then Flush, then handshake.
REQ-017 A same-cycle transfer out SHALL be treated as completed even when Flush=1.
REQ-018 Data registers SHALL load only on their load events; a held entry SHALL be stable while OutValid=1 and OutReady=0.
REQ-019 StallCount SHALL increment on every edge with OutValid=1 and OutReady=0, and SHALL saturate at all-ones.
REQ-020 BubbleCount SHALL increment on every edge where OutValid=0 and Reset=0, and SHALL saturate at all-ones.
REQ-021 Flush SHALL not clear either counter.

Reset
REQ-022 Reset=1 at a rising edge SHALL force state EMPTY, InReady=1, OutValid=0, OutCtrl=0, OutData=0, skid contents=0, StallCount=0 and BubbleCount=0.
REQ-023 Reset asserted mid-operation SHALL discard all held entries with no transfer out in that cycle.
REQ-024 The block SHALL need no initial blocks for correct operation.

Verification
REQ-025 Streaming: OutReady=1, InValid=1 for 4 cycles with data 0x1..0x4 -> OutData shows 0x1..0x4 on consecutive cycles one cycle later, and StallCount=0.
REQ-026 Backpressure: OutReady=0 while sending A=0xA, B=0xB -> SKID, InReady=0, OutData=0xA held; then OutReady=1 for 2 cycles -> outputs A then B, ending in EMPTY.
REQ-027 Flush in SKID with InValid=1, C=0xC -> next cycle OutValid=0, OutCtrl=0, InReady=1, and C never appears at the output.
REQ-028 Bubble gating: InCtrl=all-ones with InValid=0 -> OutCtrl stays 0 and BubbleCount increments by 1 per cycle.
REQ-029 Saturation with CNT_W=4: OutValid=1, OutReady=0 for 20 cycles -> StallCount stops at 15.
REQ-030 Reset during FULL with StallCount=3 -> next cycle OutValid=0, OutData=0, StallCount=0, InReady=1.
